// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Shares one GMII transmit path among N_PORT FWFT frame sources. For each frame it
//   picks one source, emits 7x 0x55 preamble and the 0xD5 SFD, streams the payload,
//   zero-pads it to MIN_PLD bytes, then holds the line idle for the downstream
//   FCS (CRC_BYTES) plus the inter-frame gap (IFG_BYTES).
// Ports
//   clk, rst_n          GMII clock, asynchronous active-low reset
//   src_valid[N]        port i has a complete frame, first byte presented (FWFT)
//   src_data[8N]        byte of port i on [8i+7:8i]
//   src_last[N]         current byte is the last payload byte of the frame
//   src_err[N]          current byte is errored
//   src_rd[N]           pop strobe toward the granted source (combinational)
//   gnt[N]              one-hot owner of the current frame (registered)
//   out_dv/out_er/out_data  GMII toward the CRC appender (registered)
module gmii_tx_arbiter #(
  parameter int unsigned N_PORT    = 4,
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned CRC_BYTES = 4,
  parameter int unsigned MIN_PLD   = 60,
  parameter int unsigned MAX_PLD   = 1514,
  parameter bit          PRIO_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_PORT-1:0]     src_valid,
  input  logic [8*N_PORT-1:0]   src_data,
  input  logic [N_PORT-1:0]     src_last,
  input  logic [N_PORT-1:0]     src_err,
  output logic [N_PORT-1:0]     src_rd,
  output logic [N_PORT-1:0]     gnt,
  output logic                  out_dv,
  output logic                  out_er,
  output logic [7:0]            out_data
);

  localparam int unsigned PW      = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int unsigned PW1     = PW + 1;
  localparam int unsigned CW      = 11;
  localparam int unsigned GAP_LEN = CRC_BYTES + IFG_BYTES;
  localparam int unsigned PHW     = $clog2(GAP_LEN + 8);
  // The arbitration cycle already emits the first 0x55, so PRE covers the other six.
  localparam int unsigned PRE_LAST = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_PLD, S_PAD, S_GAP
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     gidx, gidx_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [N_PORT-1:0] gnt_n;
  logic [CW-1:0]     byte_cnt, byte_cnt_n, byte_inc;
  logic [PHW-1:0]    ph_cnt, ph_cnt_n;
  logic              dv_n, er_n;
  logic [7:0]        data_n;

  logic              cur_valid, cur_last, cur_err;
  logic [7:0]        cur_data;
  logic [PW-1:0]     win_idx;
  logic              win_found;
  logic [PW1-1:0]    cand;

  // Signals of the currently granted source.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_err   = 1'b0;
    cur_data  = 8'h00;
    for (int i = 0; i < N_PORT; i++) begin
      if (gidx == PW'(i)) begin
        cur_valid = src_valid[i];
        cur_last  = src_last[i];
        cur_err   = src_err[i];
        cur_data  = src_data[8*i +: 8];
      end
    end
  end

  // Round-robin scan starting at ptr (the port after the last winner); optional
  // strict priority for port 0 overrides it.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_PORT; i++) begin
      cand = {1'b0, ptr} + PW1'(i);
      if (cand >= PW1'(N_PORT)) cand = cand - PW1'(N_PORT);
      if (!win_found && src_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
    if (PRIO_EN && src_valid[0]) win_idx = '0;
  end

  // Payload counter saturates so huge frames cannot wrap back under MAX_PLD.
  assign byte_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + CW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    gidx_n     = gidx;
    ptr_n      = ptr;
    gnt_n      = gnt;
    byte_cnt_n = byte_cnt;
    ph_cnt_n   = ph_cnt;
    dv_n       = 1'b0;
    er_n       = 1'b0;
    data_n     = 8'h00;
    src_rd     = '0;
    case (state)
      S_IDLE: begin
        if (|src_valid) begin
          gnt_n      = N_PORT'(1) << win_idx;
          gidx_n     = win_idx;
          ptr_n      = (win_idx == PW'(N_PORT - 1)) ? '0 : win_idx + PW'(1);
          byte_cnt_n = '0;
          ph_cnt_n   = '0;
          dv_n       = 1'b1;
          data_n     = 8'h55;
          state_n    = S_PRE;
        end
      end
      S_PRE: begin
        dv_n   = 1'b1;
        data_n = 8'h55;
        if (ph_cnt == PHW'(PRE_LAST)) state_n = S_SFD;
        else                          ph_cnt_n = ph_cnt + PHW'(1);
      end
      S_SFD: begin
        dv_n    = 1'b1;
        data_n  = 8'hD5;
        state_n = S_PLD;
      end
      S_PLD: begin
        dv_n = 1'b1;
        if (cur_valid) begin
          src_rd     = gnt;
          data_n     = cur_data;
          er_n       = cur_err | (byte_cnt >= CW'(MAX_PLD));
          byte_cnt_n = byte_inc;
          if (cur_last) begin
            if (byte_cnt < CW'(MIN_PLD - 1)) begin
              state_n = S_PAD;
            end else begin
              state_n  = S_GAP;
              gnt_n    = '0;
              ph_cnt_n = '0;
            end
          end
        end else begin
          // Source underrun: mark the hole and keep waiting; nothing is popped.
          er_n   = 1'b1;
          data_n = 8'h00;
        end
      end
      S_PAD: begin
        dv_n       = 1'b1;
        byte_cnt_n = byte_inc;
        if (byte_cnt == CW'(MIN_PLD - 1)) begin
          state_n  = S_GAP;
          gnt_n    = '0;
          ph_cnt_n = '0;
        end
      end
      S_GAP: begin
        if (ph_cnt == PHW'(GAP_LEN - 1)) state_n = S_IDLE;
        else                             ph_cnt_n = ph_cnt + PHW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gidx     <= '0;
      ptr      <= '0;
      gnt      <= '0;
      byte_cnt <= '0;
      ph_cnt   <= '0;
      out_dv   <= 1'b0;
      out_er   <= 1'b0;
      out_data <= 8'h00;
    end else begin
      state    <= state_n;
      gidx     <= gidx_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      byte_cnt <= byte_cnt_n;
      ph_cnt   <= ph_cnt_n;
      out_dv   <= dv_n;
      out_er   <= er_n;
      out_data <= data_n;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter
//   Two arbiters side by side: dut0 round-robin, dut1 with port-0 priority. Each has
//   its own FWFT frame-source model; a monitor records every output frame.
module tb_gmii_tx_arbiter;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  logic [1:0][N-1:0]   src_valid;
  logic [1:0][8*N-1:0] src_data;
  logic [1:0][N-1:0]   src_last;
  logic [1:0][N-1:0]   src_err;
  logic [1:0][N-1:0]   src_rd;
  logic [1:0][N-1:0]   gnt;
  logic [1:0]          out_dv;
  logic [1:0]          out_er;
  logic [1:0][7:0]     out_data;

  gmii_tx_arbiter #(.N_PORT(N), .PRIO_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid[0]), .src_data(src_data[0]), .src_last(src_last[0]),
    .src_err(src_err[0]), .src_rd(src_rd[0]), .gnt(gnt[0]),
    .out_dv(out_dv[0]), .out_er(out_er[0]), .out_data(out_data[0])
  );

  gmii_tx_arbiter #(.N_PORT(N), .PRIO_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid[1]), .src_data(src_data[1]), .src_last(src_last[1]),
    .src_err(src_err[1]), .src_rd(src_rd[1]), .gnt(gnt[1]),
    .out_dv(out_dv[1]), .out_er(out_er[1]), .out_data(out_data[1])
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Source model: per-port byte FIFO of {err, last, data}.
  logic [9:0]  smem [2][N][4096];
  logic [11:0] rp [2][N];
  logic [11:0] wp [2][N];
  logic        hold [2][N];

  initial begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++) begin
        rp[d][p]   = '0;
        wp[d][p]   = '0;
        hold[d][p] = 1'b0;
      end
  end

  always_ff @(posedge clk)
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++)
        if (src_rd[d][p]) rp[d][p] <= rp[d][p] + 12'd1;

  always_comb begin
    src_valid = '0;
    src_data  = '0;
    src_last  = '0;
    src_err   = '0;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < N; p++) begin
        src_valid[d][p]       = (rp[d][p] != wp[d][p]) && !hold[d][p];
        src_data[d][8*p +: 8] = smem[d][p][rp[d][p]][7:0];
        src_last[d][p]        = smem[d][p][rp[d][p]][8];
        src_err[d][p]         = smem[d][p][rp[d][p]][9];
      end
  end

  // Monitor: captures frames, grants at dv rise, idle run before each frame.
  logic [7:0] cap_data [2][2048];
  logic       cap_er   [2][2048];
  int         cap_len  [2];
  int         nf       [2];
  logic       in_frame [2];
  int         low_run  [2];
  int         rd_cnt   [2];
  int         rd_viol  [2];
  logic [N-1:0] gnt_log [2][32];
  int         gap_log  [2][32];
  int         len_log  [2][32];

  initial begin
    for (int d = 0; d < 2; d++) begin
      cap_len[d] = 0; nf[d] = 0; in_frame[d] = 1'b0;
      low_run[d] = 1000; rd_cnt[d] = 0; rd_viol[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (out_dv[d]) begin
          if (!in_frame[d]) begin
            in_frame[d] = 1'b1;
            cap_len[d]  = 0;
            rd_cnt[d]   = 0;
            if (nf[d] < 32) begin
              gnt_log[d][nf[d]] = gnt[d];
              gap_log[d][nf[d]] = low_run[d];
            end
          end
          if (cap_len[d] < 2048) begin
            cap_data[d][cap_len[d]] = out_data[d];
            cap_er[d][cap_len[d]]   = out_er[d];
          end
          cap_len[d] = cap_len[d] + 1;
          low_run[d] = 0;
        end else begin
          if (in_frame[d]) begin
            in_frame[d] = 1'b0;
            if (nf[d] < 32) len_log[d][nf[d]] = cap_len[d];
            nf[d] = nf[d] + 1;
          end
          low_run[d] = low_run[d] + 1;
        end
        if (|src_rd[d]) rd_cnt[d] = rd_cnt[d] + 1;
        if (((src_rd[d] & ~gnt[d]) != '0) || ($countones(src_rd[d]) > 1))
          rd_viol[d] = rd_viol[d] + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_frame(input int d, input int p, input int len, input int seed,
                            input int err_pos);
    logic [11:0] w;
    w = wp[d][p];
    for (int k = 1; k <= len; k++) begin
      smem[d][p][w] = {(k == err_pos), (k == len), 8'(k + seed)};
      w = w + 12'd1;
    end
    wp[d][p] = w;
  endtask

  task automatic wait_frames(input int d, input int n, input string name);
    int c;
    c = 0;
    while (nf[d] < n && c < 5000) begin
      @(negedge clk); #1;
      c++;
    end
    if (nf[d] < n) check({name, " timeout"}, nf[d], n);
  endtask

  // Builds the expected frame from the payload description and compares it.
  logic [7:0] e_d [2048];
  logic       e_e [2048];
  task automatic check_content(input int d, input string name, input int start_k,
                               input int len, input int seed, input int err_pos,
                               input int hole_after);
    int n, j, mism, ers;
    n = 0;
    for (int i = 0; i < 7; i++) begin e_d[n] = 8'h55; e_e[n] = 1'b0; n++; end
    e_d[n] = 8'hD5; e_e[n] = 1'b0; n++;
    j = 0;
    for (int k = start_k; k <= len; k++) begin
      if (hole_after > 0 && j == hole_after && k == start_k + hole_after) begin
        e_d[n] = 8'h00; e_e[n] = 1'b1; n++;
      end
      j++;
      e_d[n] = 8'(k + seed);
      e_e[n] = (k == err_pos) || (j > 1514);
      n++;
    end
    while (j < 60) begin e_d[n] = 8'h00; e_e[n] = 1'b0; n++; j++; end
    check({name, " dv_len"}, cap_len[d], n);
    mism = 0;
    ers  = 0;
    for (int i = 0; i < n && i < 2048; i++) begin
      if (cap_data[d][i] !== e_d[i] || cap_er[d][i] !== e_e[i]) mism++;
      if (cap_er[d][i] === 1'b1) ers++;
    end
    check({name, " byte_mismatches"}, mism, 0);
    if (len > 1514 || hole_after > 0)
      check({name, " er_count"}, ers, (hole_after > 0 ? 1 : 0) + (len > 1514 ? len - 1514 : 0));
  endtask

  typedef struct {
    int port;
    int len;
    int seed;
    int err_pos;
    int exp_gnt;
    int exp_dv;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int base, c;
    vecs[0] = '{1,   64, 'h00,  0, 'b0010,   72};
    vecs[1] = '{0,   20, 'h10,  0, 'b0001,   68};
    vecs[2] = '{2,   60, 'h20,  0, 'b0100,   68};
    vecs[3] = '{3,   59, 'h30,  5, 'b1000,   68};
    vecs[4] = '{1,    1, 'h40,  0, 'b0010,   68};
    vecs[5] = '{0,   61, 'h50, 61, 'b0001,   69};
    vecs[6] = '{2, 1514, 'h60,  0, 'b0100, 1522};

    // Reset values, during and right after reset.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst out_dv", int'(out_dv), 0);
    check("rst out_er", int'(out_er), 0);
    check("rst out_data", int'(out_data), 0);
    check("rst gnt", int'(gnt), 0);
    check("rst src_rd", int'(src_rd), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post-rst out_dv", int'(out_dv), 0);

    // Round-robin from pointer 0 on dut0; port-0 priority on dut1.
    for (int r = 0; r < 2; r++) begin
      push_frame(0, 0, 60, 'h00, 0);
      push_frame(0, 2, 60, 'h00, 0);
      push_frame(0, 3, 60, 'h00, 0);
      push_frame(1, 0, 60, 'h00, 0);
      push_frame(1, 1, 60, 'h00, 0);
    end
    wait_frames(0, 6, "rr");
    wait_frames(1, 4, "prio");
    for (int i = 0; i < 6; i++) begin
      logic [3:0] eg;
      eg = (i % 3 == 0) ? 4'b0001 : (i % 3 == 1) ? 4'b0100 : 4'b1000;
      check($sformatf("rr gnt[%0d]", i), int'(gnt_log[0][i]), int'(eg));
      check($sformatf("rr len[%0d]", i), len_log[0][i], 68);
      if (i > 0) check($sformatf("rr gap[%0d]", i), gap_log[0][i], 16);
    end
    for (int i = 0; i < 4; i++) begin
      logic [3:0] eg;
      eg = (i < 2) ? 4'b0001 : 4'b0010;
      check($sformatf("prio gnt[%0d]", i), int'(gnt_log[1][i]), int'(eg));
      if (i > 0) check($sformatf("prio gap[%0d]", i), gap_log[1][i], 16);
    end

    // Single-frame table on dut0.
    for (int v = 0; v < 7; v++) begin
      base = nf[0];
      push_frame(0, vecs[v].port, vecs[v].len, vecs[v].seed, vecs[v].err_pos);
      wait_frames(0, base + 1, $sformatf("vec%0d", v));
      check($sformatf("vec%0d gnt", v), int'(gnt_log[0][base]), vecs[v].exp_gnt);
      check($sformatf("vec%0d dv_cycles", v), len_log[0][base], vecs[v].exp_dv);
      check($sformatf("vec%0d src_rd_cycles", v), rd_cnt[0], vecs[v].len);
      check_content(0, $sformatf("vec%0d", v), 1, vecs[v].len, vecs[v].seed,
                    vecs[v].err_pos, 0);
      repeat (20) @(negedge clk);
    end

    // Oversize frame: bytes beyond 1514 flagged.
    base = nf[0];
    push_frame(0, 3, 1520, 'h05, 0);
    wait_frames(0, base + 1, "oversize");
    check_content(0, "oversize", 1, 1520, 'h05, 0, 0);
    repeat (20) @(negedge clk);

    // Underrun: one-cycle src_valid drop after the 10th pop.
    base = nf[0];
    push_frame(0, 1, 64, 'h11, 0);
    c = 0;
    while (!(in_frame[0] && rd_cnt[0] >= 10) && c < 500) begin @(negedge clk); #1; c++; end
    check("underrun reached byte 10", rd_cnt[0], 10);
    @(posedge clk); #1;
    hold[0][1] = 1'b1;
    @(posedge clk); #1;
    hold[0][1] = 1'b0;
    wait_frames(0, base + 1, "underrun");
    check_content(0, "underrun", 1, 64, 'h11, 0, 10);
    repeat (20) @(negedge clk);

    // Reset in the middle of the payload; remnant goes out as a fresh frame.
    base = nf[0];
    push_frame(0, 2, 64, 'h70, 0);
    c = 0;
    while (!(in_frame[0] && rd_cnt[0] >= 30) && c < 500) begin @(negedge clk); #1; c++; end
    check("midrst reached byte 30", rd_cnt[0], 30);
    rst_n = 1'b0;
    #1;
    check("midrst out_dv", int'(out_dv[0]), 0);
    check("midrst gnt", int'(gnt[0]), 0);
    check("midrst src_rd", int'(src_rd[0]), 0);
    check("midrst out_data", int'(out_data[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_frames(0, base + 2, "midrst");
    check("midrst regrant", int'(gnt_log[0][base + 1]), 'b0100);
    check_content(0, "midrst remnant", 30, 64, 'h70, 0, 0);

    check("dut0 src_rd outside grant", rd_viol[0], 0);
    check("dut1 src_rd outside grant", rd_viol[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
